// File: rtl/lat_run_sequencer_if.sv
// Control/status bundle between the register block, the run sequencer,
// and the GT reset / latency-capture logic.
interface lat_run_sequencer_if;
  logic        start;
  logic        abort;
  logic [15:0] pkt_cnt;
  logic        link_stable;
  logic [15:0] lat_pending;
  logic [31:0] lat_delta_idx;
  logic        gtwiz_reset_all;
  logic        lat_clear;
  logic        lat_enable;
  logic        busy;
  logic        done;
  logic [2:0]  err_code;

  modport master (
    output start, abort, pkt_cnt,
    output link_stable, lat_pending, lat_delta_idx,
    input  gtwiz_reset_all, lat_clear, lat_enable,
    input  busy, done, err_code
  );

  modport slave (
    input  start, abort, pkt_cnt,
    input  link_stable, lat_pending, lat_delta_idx,
    output gtwiz_reset_all, lat_clear, lat_enable,
    output busy, done, err_code
  );
endinterface

// File: rtl/lat_run_sequencer.sv
// lat_run_sequencer: one latency run (GT reset, link wait, clear, capture,
// drain) started by a single pulse, reporting busy/done/err_code.
// Ports: aclk, areset (sync, active high), bus (slave modport):
//   in  start abort pkt_cnt link_stable lat_pending lat_delta_idx
//   out gtwiz_reset_all lat_clear lat_enable busy done err_code
// Macro LAT_SEQ_GT_RESET_EN builds the RESET state; otherwise a start
// goes straight to WAIT_LINK and gtwiz_reset_all is tied low.
module lat_run_sequencer #(
  parameter int unsigned      RST_CYCLES = 16,
  parameter int unsigned      TMO_W      = 24,
  parameter logic [TMO_W-1:0] LINK_TMO   = TMO_W'(24'hFF_FFFF),
  parameter logic [TMO_W-1:0] RUN_TMO    = TMO_W'(24'hFF_FFFF),
  parameter logic [TMO_W-1:0] DRAIN_TMO  = TMO_W'(24'h00_FFFF)
) (
  input logic                aclk,
  input logic                areset,
  lat_run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_e;

  localparam logic [2:0] E_LINK_TMO  = 3'd1;
  localparam logic [2:0] E_LINK_LOST = 3'd2;
  localparam logic [2:0] E_RUN_TMO   = 3'd3;
  localparam logic [2:0] E_DRAIN_TMO = 3'd4;
  localparam logic [2:0] E_ABORT     = 3'd5;

`ifdef LAT_SEQ_GT_RESET_EN
  localparam logic [TMO_W-1:0] RstLast =
    TMO_W'(RST_CYCLES - 1);
  localparam state_e StartNext = S_RESET;
  logic gt_q;
`else
  localparam state_e StartNext = S_WAIT;
`endif

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmr_q, tmr_d;
  logic [15:0]      pkt_q, pkt_d;
  logic [2:0]       err_q, err_d, ev;
  logic             clr_q, en_q, busy_q, done_q;

  // tmr counts cycles already spent in the state, so the limit is
  // reached in the cycle where tmr+1 equals it.
  function automatic logic expired(
    input logic [TMO_W-1:0] t,
    input logic [TMO_W-1:0] lim
  );
    return ({1'b0, t} + (TMO_W+1)'(1)) >= {1'b0, lim};
  endfunction

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    err_d   = err_q;
    ev      = '0;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = StartNext;
          pkt_d   = bus.pkt_cnt;
          err_d   = '0;
        end
      end
`ifdef LAT_SEQ_GT_RESET_EN
      S_RESET: begin
        if (tmr_q == RstLast) state_d = S_WAIT;
      end
`endif
      S_WAIT: begin
        if (bus.link_stable) begin
          state_d = S_CLEAR;
        end else if (expired(tmr_q, LINK_TMO)) begin
          ev      = E_LINK_TMO;
          state_d = S_FINISH;
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (bus.lat_delta_idx >= {16'b0, pkt_q}) begin
          state_d = S_DRAIN;
        end else if (expired(tmr_q, RUN_TMO)) begin
          ev      = E_RUN_TMO;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.lat_pending == '0) begin
          state_d = S_FINISH;
        end else if (expired(tmr_q, DRAIN_TMO)) begin
          ev      = E_DRAIN_TMO;
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Overrides, weakest first: link loss, then abort.
    if (!bus.link_stable &&
        (state_q inside {S_CLEAR, S_RUN, S_DRAIN})) begin
      ev      = E_LINK_LOST;
      state_d = S_FINISH;
    end
    if (bus.abort &&
        (state_q inside {S_RESET, S_WAIT, S_CLEAR,
                         S_RUN, S_DRAIN})) begin
      ev      = E_ABORT;
      state_d = S_FINISH;
    end

    // First error of a run sticks.
    if (ev != '0 && err_q == '0) err_d = ev;

    if (state_d != state_q) tmr_d = '0;
    else if (!(&tmr_q))     tmr_d = tmr_q + TMO_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LAT_SEQ_GT_RESET_EN
      gt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
      clr_q   <= (state_d == S_CLEAR);
      en_q    <= (state_d == S_RUN);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FINISH);
`ifdef LAT_SEQ_GT_RESET_EN
      gt_q    <= (state_d == S_RESET);
`endif
    end
  end

`ifdef LAT_SEQ_GT_RESET_EN
  assign bus.gtwiz_reset_all = gt_q;
`else
  assign bus.gtwiz_reset_all = 1'b0;
`endif
  assign bus.lat_clear  = clr_q;
  assign bus.lat_enable = en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err_code   = err_q;

endmodule

// File: tb/tb_lat_run_sequencer.sv
// Bench for lat_run_sequencer: directed and random runs checked
// cycle by cycle against a timeline predicted from the run rules.
module tb_lat_run_sequencer;

  localparam int LTMO  = 100;
  localparam int RTMO  = 300;
  localparam int DTMO  = 50;
  localparam int MAXC  = 1024;
  localparam int NEVER = 1 << 30;
`ifdef LAT_SEQ_GT_RESET_EN
  localparam int R = 16;
`else
  localparam int R = 0;
`endif
  localparam int W = R + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lat_run_sequencer_if bus ();

  lat_run_sequencer #(
    .RST_CYCLES (16),
    .TMO_W      (24),
    .LINK_TMO   (24'd100),
    .RUN_TMO    (24'd300),
    .DRAIN_TMO  (24'd50)
  ) dut (
    .aclk   (clk),
    .areset (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Run scenario, in cycles relative to the start cycle 0.
  int          Lon, Loff, Ion, Pend, A, Sp;
  logic [31:0] base;
  logic [15:0] pkt, pv;
  logic [2:0]  prev_err = 3'd0;
  int          F;
  // {gt, clr, en, busy, done, err[2:0]} per cycle
  logic [7:0]  exp_o [MAXC];

  function automatic bit lnk(int c);
    return (c >= Lon) && (c < Loff);
  endfunction

  function automatic logic [31:0] idxf(int c);
    return (c < Ion) ? 32'd0 : base + 32'(c - Ion);
  endfunction

  function automatic logic [15:0] pendf(int c);
    return (c < Pend) ? pv : 16'd0;
  endfunction

  function automatic void put(int c, logic gt, logic clr,
                              logic en, logic [2:0] e);
    exp_o[c] = {gt, clr, en, 1'b1, 1'b0, e};
  endfunction

  function automatic void close(int f, logic [2:0] e,
                                logic [2:0] code);
    logic [2:0] fe;
    fe = (e != 3'd0) ? e : code;
    exp_o[f]     = {3'b000, 1'b1, 1'b1, fe};
    exp_o[f + 1] = {3'b000, 1'b0, 1'b0, fe};
    F        = f;
    prev_err = fe;
  endfunction

  // Walk the run phase by phase, finding the first cycle at which
  // each phase ends, with abort > link loss > success > timeout.
  function automatic void plan();
    int c;
    int t0;
    logic [2:0] e;
    for (int i = 0; i < MAXC; i++) exp_o[i] = '0;
    exp_o[0] = {5'b0, prev_err};
    e = 3'd0;
    c = 1;
    for (int k = 0; k < R; k++) begin
      put(c, 1'b1, 1'b0, 1'b0, e);
      if (c == A) begin close(c + 1, e, 3'd5); return; end
      c++;
    end
    t0 = c;
    while (1'b1) begin
      put(c, 1'b0, 1'b0, 1'b0, e);
      if (c == A) begin close(c + 1, e, 3'd5); return; end
      if (lnk(c)) break;
      if (c - t0 + 1 >= LTMO) begin
        close(c + 1, e, 3'd1); return;
      end
      c++;
    end
    c++;
    put(c, 1'b0, 1'b1, 1'b0, e);
    if (c == A) begin close(c + 1, e, 3'd5); return; end
    if (!lnk(c)) begin close(c + 1, e, 3'd2); return; end
    c++;
    t0 = c;
    while (1'b1) begin
      put(c, 1'b0, 1'b0, 1'b1, e);
      if (c == A) begin close(c + 1, e, 3'd5); return; end
      if (!lnk(c)) begin close(c + 1, e, 3'd2); return; end
      if (idxf(c) >= {16'd0, pkt}) break;
      if (c - t0 + 1 >= RTMO) begin e = 3'd3; break; end
      c++;
    end
    c++;
    t0 = c;
    while (1'b1) begin
      put(c, 1'b0, 1'b0, 1'b0, e);
      if (c == A) begin close(c + 1, e, 3'd5); return; end
      if (!lnk(c)) begin close(c + 1, e, 3'd2); return; end
      if (pendf(c) == 16'd0) begin
        close(c + 1, e, 3'd0); return;
      end
      if (c - t0 + 1 >= DTMO) begin
        close(c + 1, e, 3'd4); return;
      end
      c++;
    end
  endfunction

  function automatic logic [7:0] sample();
    return {bus.gtwiz_reset_all, bus.lat_clear,
            bus.lat_enable, bus.busy, bus.done,
            bus.err_code};
  endfunction

  task automatic drive(int c);
    bus.start         = (c == 0) || (c == Sp);
    bus.pkt_cnt       = (c == 0) ? pkt : 16'($urandom);
    bus.abort         = (c == A);
    bus.link_stable   = lnk(c);
    bus.lat_delta_idx = idxf(c);
    bus.lat_pending   = pendf(c);
  endtask

  task automatic set_run(int lon, int loff, int ion,
                         logic [31:0] b, logic [15:0] p,
                         int pend, logic [15:0] pval,
                         int a, int sp);
    Lon = lon; Loff = loff; Ion = ion; base = b;
    pkt = p; Pend = pend; pv = pval; A = a; Sp = sp;
  endtask

  task automatic run_one(string tag);
    logic [7:0] obs;
    plan();
    if (Sp < 0) Sp = $urandom_range(1, F);
    for (int c = 0; c <= F + 1; c++) begin
      @(negedge clk);
      obs = sample();
      checks++;
      assert (obs === exp_o[c]) else begin
        failures++;
        $error("FAIL %s cyc=%0d got=%b want=%b",
               tag, c, obs, exp_o[c]);
      end
      drive(c);
    end
  endtask

  initial begin
    logic [7:0] obs;
    bit hit;
    bit seen;
    rst = 1'b1;
    set_run(NEVER, NEVER, NEVER, 0, 0, 0, 0, -1, -1);
    bus.start = 1'b0; bus.abort = 1'b0; bus.pkt_cnt = '0;
    bus.link_stable = 1'b0; bus.lat_pending = '0;
    bus.lat_delta_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = sample();
    checks++;
    assert (obs === 8'd0) else begin
      failures++;
      $error("FAIL reset_state got=%b want=%b", obs, 8'd0);
    end
    rst = 1'b0;

    set_run(W + 20, NEVER, W + 27, 0, 8, W + 45, 5, -1, W + 3);
    run_one("nominal");
    set_run(NEVER, NEVER, 0, 0, 4, 0, 1, -1, 2);
    run_one("link_tmo");
    set_run(W + 2, W + 12, NEVER, 0, 50, 0, 1, -1, 1);
    run_one("link_lost");
    set_run(W, NEVER, 0, 0, 0, NEVER, 3, -1, 1);
    run_one("zero_cnt_drain_tmo");
    set_run(W, NEVER, NEVER, 0, 20, 0, 1, W + 6, 1);
    run_one("abort_run");
    set_run(W, NEVER, 0, 0, 3, 0, 2, 0, 1);
    run_one("start_abort_idle");
    set_run(W, NEVER, NEVER, 0, 7, 0, 1, -1, 1);
    run_one("run_tmo");
    set_run(W, NEVER, 0, 32'h0001_0000, 16'hFFFF,
            W + 10, 9, -1, 1);
    run_one("idx_hi_bits");

    for (int r = 0; r < 12; r++) begin
      Lon  = $urandom_range(0, R + 120);
      Loff = $urandom_range(0, 1) ? NEVER
           : Lon + $urandom_range(1, 200);
      Ion  = $urandom_range(0, 150);
      base = ($urandom_range(0, 7) == 0) ? 32'h0001_0000 : 0;
      pkt  = 16'($urandom_range(0, 40));
      Pend = $urandom_range(0, 250);
      pv   = 16'($urandom_range(1, 65535));
      A    = $urandom_range(0, 1) ? -1 : $urandom_range(0, 400);
      Sp   = -1;
      run_one("random");
    end

    // areset in the middle of RUN
    set_run(0, NEVER, NEVER, 0, 10, 0, 1, -1, -5);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (bus.lat_enable === 1'b1) hit = 1'b1;
      else drive(c);
    end
    checks++;
    assert (hit === 1'b1) else begin
      failures++;
      $error("FAIL areset_reach_run got=%b want=1", hit);
    end
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    obs = sample();
    checks++;
    assert (obs === 8'd0) else begin
      failures++;
      $error("FAIL areset_outputs got=%b want=%b", obs, 8'd0);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    assert (seen === 1'b0) else begin
      failures++;
      $error("FAIL areset_no_done got=%b want=0", seen);
    end
    prev_err = 3'd0;

    set_run(W + 5, NEVER, 0, 0, 6, W + 30, 2, -1, -1);
    run_one("after_areset");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
